// File: rtl/frequency_generator.sv
// Clock-enable style divider: derives a slow square wave and a one-cycle tick
// at each rising edge of that wave from the fast system clock.
module frequency_generator #(
  parameter int unsigned INPUT_FREQUENCY = 50_000_000,
  parameter int unsigned frequency       = 1,
  parameter int unsigned bitsNumber      = 30
) (
  input  logic InputCLK,
  input  logic Reset,
  input  logic Enable,
  output logic OutputCLK,
  output logic Tick
);

  localparam int unsigned HALF =
    (frequency == 0) ? 0 : INPUT_FREQUENCY / (32'd2 * frequency);
  localparam longint unsigned HALF_M1_L = (HALF == 0) ? 64'd0 : 64'(HALF) - 64'd1;
  localparam logic [bitsNumber-1:0] HALF_M1 = HALF_M1_L[bitsNumber-1:0];

  // Reject ratios that cannot be built or whose terminal count overflows the counter
  if (frequency == 0 || HALF == 0 || HALF_M1_L >= (64'd1 << bitsNumber)) begin : g_bad_params
    $error("frequency_generator: illegal INPUT_FREQUENCY/frequency/bitsNumber combination");
  end

  logic [bitsNumber-1:0] counter_q, counter_d;
  logic                  out_q, out_d;
  logic                  tick_q, tick_d;

  always_comb begin
    counter_d = counter_q;
    out_d     = out_q;
    tick_d    = 1'b0;
    if (Enable) begin
      if (counter_q == HALF_M1) begin
        counter_d = '0;
        out_d     = ~out_q;
        tick_d    = ~out_q;
      end else begin
        counter_d = counter_q + bitsNumber'(1);
      end
    end
  end

  always_ff @(posedge InputCLK or posedge Reset) begin
    if (Reset) begin
      counter_q <= '0;
      out_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      out_q     <= out_d;
      tick_q    <= tick_d;
    end
  end

  assign OutputCLK = out_q;
  assign Tick      = tick_q;

endmodule

// File: tb/tb_frequency_generator.sv
// Directed bench for frequency_generator: several divide ratios, enable gaps,
// asynchronous reset while the output is high.
module tb_frequency_generator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en5 = 1'b0;
  logic en_oth = 1'b0;

  logic out5, tick5, out1, tick1, out1t, tick1t, out3, tick3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // HALF=5 (narrow counter: terminal count 4 fits in 3 bits)
  frequency_generator #(.INPUT_FREQUENCY(100), .frequency(10), .bitsNumber(3)) u_h5 (
    .InputCLK(clk), .Reset(rst), .Enable(en5), .OutputCLK(out5), .Tick(tick5));
  // HALF=1 exact
  frequency_generator #(.INPUT_FREQUENCY(20), .frequency(10), .bitsNumber(30)) u_h1 (
    .InputCLK(clk), .Reset(rst), .Enable(en_oth), .OutputCLK(out1), .Tick(tick1));
  // HALF=1 truncated from 1.5
  frequency_generator #(.INPUT_FREQUENCY(30), .frequency(10), .bitsNumber(30)) u_t1 (
    .InputCLK(clk), .Reset(rst), .Enable(en_oth), .OutputCLK(out1t), .Tick(tick1t));
  // HALF=3
  frequency_generator #(.INPUT_FREQUENCY(70), .frequency(10), .bitsNumber(30)) u_h3 (
    .InputCLK(clk), .Reset(rst), .Enable(en_oth), .OutputCLK(out3), .Tick(tick3));

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %b, want %b", name, idx, act, exp);
    end
  endtask

  // Expected square wave after n enabled edges from reset, half-period h
  function automatic logic exp_out(input int n, input int h);
    return 1'((n / h) % 2);
  endfunction
  function automatic logic exp_tick(input int n, input int h);
    return (n > 0) && (n % h == 0) && exp_out(n, h);
  endfunction

  typedef struct packed {
    logic en;
    logic out;
    logic tick;
  } vec_t;

  localparam int unsigned NVEC = 22;
  vec_t tbl [NVEC];

  initial begin
    // HALF=5 with a 3-cycle enable gap after edge 2, then a 2-cycle gap while high
    tbl[0]  = '{1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b0};
    tbl[21] = '{1'b1, 1'b1, 1'b0};

    // Reset held with random enables: everything stays low
    for (int i = 0; i < 6; i++) begin
      en5    = 1'($urandom_range(0, 1));
      en_oth = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_out5", i, out5, 1'b0);
      check("rst_tick5", i, tick5, 1'b0);
      check("rst_out1", i, out1, 1'b0);
      check("rst_out3", i, out3, 1'b0);
      check("rst_tick3", i, tick3, 1'b0);
    end

    // Free-running: 6 periods of HALF=5, many more of the faster instances
    en5 = 1'b1;
    en_oth = 1'b1;
    rst = 1'b0;
    for (int n = 1; n <= 65; n++) begin
      @(negedge clk);
      check("run_out5", n, out5, exp_out(n, 5));
      check("run_tick5", n, tick5, exp_tick(n, 5));
      check("run_out1", n, out1, exp_out(n, 1));
      check("run_tick1", n, tick1, exp_tick(n, 1));
      check("run_out1t", n, out1t, exp_out(n, 1));
      check("run_tick1t", n, tick1t, exp_tick(n, 1));
      check("run_out3", n, out3, exp_out(n, 3));
      check("run_tick3", n, tick3, exp_tick(n, 3));
    end

    // After 65 edges u_h5 is in its high phase; reset between edges clears at once
    check("pre_async_out5", 0, out5, 1'b1);
    rst = 1'b1;
    #1;
    check("async_out5", 0, out5, 1'b0);
    check("async_tick5", 0, tick5, 1'b0);
    check("async_out3", 0, out3, 1'b0);
    @(negedge clk);
    check("rst_hold_out5", 0, out5, 1'b0);
    check("rst_hold_out1", 0, out1, 1'b0);

    // Table-driven enable-gap sequence on HALF=5 from a fresh reset release
    rst = 1'b0;
    for (int i = 0; i < int'(NVEC); i++) begin
      en5 = tbl[i].en;
      @(negedge clk);
      check("tbl_out5", i, out5, tbl[i].out);
      check("tbl_tick5", i, tick5, tbl[i].tick);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
